// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state type and size/alignment helpers for the LSU memory port.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  // Undefined funct3 codes fall through to word size.
  function automatic lsu_size_t size_of(input logic [2:0] f3);
    if (f3 == F3_B || f3 == F3_BU) return SZ_B;
    if (f3 == F3_H || f3 == F3_HU) return SZ_H;
    return SZ_W;
  endfunction

  function automatic logic is_zext(input logic [2:0] f3);
    return !(f3 == F3_B || f3 == F3_H);
  endfunction

  function automatic logic [1:0] align_lo(input lsu_size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    return lo;
      SZ_H:    return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input lsu_size_t sz, input logic [1:0] lo);
    return (sz == SZ_H && lo[0]) || (sz == SZ_W && lo != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / replicated write data, load lane select and extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  lsu_size_t         size_i,
  input  logic              zext_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [3:0]        be_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   rdata_o
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata_i[8*gi +: 8];
  end

  assign byte_sel = lane[addr_lo_i];
  assign half_sel = addr_lo_i[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {(XLEN/8){wdata_i[7:0]}};
        rdata_o = {{(XLEN-8){~zext_i & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {(XLEN/16){wdata_i[15:0]}};
        rdata_o = {{(XLEN-16){~zext_i & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Single-outstanding load/store initiator for a 1-cycle-latency byte-enabled memory port.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses respond with resp_err instead of being aligned.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int XLEN          = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH+1:0] req_addr,
  input  logic [XLEN-1:0]          req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [XLEN-1:0]          resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [3:0]               mem_be,
  output logic [XLEN-1:0]          mem_wdata,
  output logic                     mem_we,
  input  logic [XLEN-1:0]          mem_rdata
);

  localparam int BAW = ADDRESS_WIDTH + 2;

  lsu_state_t      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [BAW-1:0]  addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  lsu_size_t       req_size;
  logic            req_mis;
  logic [3:0]      be_lane;
  logic [XLEN-1:0] wdata_lane;
  logic [XLEN-1:0] rdata_ext;

  assign req_size = size_of(req_funct3);

`ifdef MISALIGN_TRAP_EN
  assign req_mis = misaligned(req_size, req_addr[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  lsu_align #(.XLEN(XLEN)) u_align (
    .size_i    (size_of(f3_q)),
    .zext_i    (is_zext(f3_q)),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .be_o      (be_lane),
    .wdata_o   (wdata_lane),
    .rdata_o   (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          // Low bits snapped to natural alignment; a trapped access never reaches memory anyway.
          addr_d  = {req_addr[BAW-1:2], align_lo(req_size, req_addr[1:0])};
          rdata_d = '0;
          err_d   = req_mis;
          state_d = req_mis ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = we_q ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        rdata_d = rdata_ext;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_DONE);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    if (state_q == ST_ISSUE) begin
      mem_addr  = addr_q[BAW-1:2];
      mem_be    = be_lane;
      mem_wdata = wdata_lane;
      mem_we    = we_q;
    end
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator for the multicycle core's byte-enabled data memory port: accepts one load or store request at a time from the core control FSM, converts the byte address and RISC-V funct3 size into word address, byte enables and lane-shifted write data, drives the single-cycle-latency synchronous memory port, and returns sign/zero-extended load data. Sits between the datapath/control unit and one port of the data memory.

## Interface
- ADDRESS_WIDTH, 9: word-address bits of the memory port; byte address uses ADDRESS_WIDTH+2 bits.
- XLEN, 32: core data width; memory word is 4 bytes.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block idle, request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- req_addr  in  ADDRESS_WIDTH+2  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  response present; held until resp_ready.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  XLEN  extended load data (0 for stores).
- resp_err  out  1  misaligned access (only with MISALIGN_TRAP_EN).
- mem_addr  out  ADDRESS_WIDTH  word address = req_addr[ADDRESS_WIDTH+1:2].
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_we  out  1  write strobe.
- mem_rdata  in  XLEN  registered memory read data, valid the cycle after address presented.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. On accept, register we, funct3, addr, wdata -> ISSUE.
- ISSUE: mem_addr/mem_be/mem_wdata from registers; mem_we=req_we_q (only state with mem_we=1). Load -> WAIT; store -> DONE.
- WAIT: mem_rdata valid; select byte/half by addr[1:0], sign- or zero-extend per funct3, register into resp_rdata -> DONE.
- DONE: resp_valid=1; on resp_ready -> IDLE. No new request accepted before IDLE.
- Byte enables: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<{addr[1],1'b0}; W -> 4'b1111.
- Store lanes: B replicates wdata[7:0] to all 4 lanes; H replicates wdata[15:0] to both halves; W passes through.
- Loads still drive mem_be per size; memory ignores be on reads.
- Undefined funct3 (011, 110, 111): treated as W, unsigned.
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.

## Timing
- Accept at edge E0. ISSUE is cycle after E0; memory samples address/write at end of ISSUE.
- Load: resp_valid high 3 cycles after accept edge (ISSUE, WAIT, DONE).
- Store: resp_valid high 2 cycles after accept; write committed at end of ISSUE.
- Back-to-back: with resp_ready held 1, next accept in cycle following DONE; throughput 1 load / 4 cycles, 1 store / 3 cycles.
- Reset mid-operation: next edge forces IDLE and drops resp; a write whose ISSUE cycle coincides with the reset edge still commits (memory has no reset).
- resp_valid, once high, holds with stable resp_rdata/resp_err until resp_ready.

## Configuration
- MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 skips ISSUE/WAIT (no memory access, mem_we stays 0), goes IDLE->ISSUE-free path to DONE with resp_err=1, resp_rdata=0, 1 cycle after accept.
- Undefined: resp_err tied 0; low address bits forced to natural alignment (H clears addr[0], W clears addr[1:0]) and access proceeds normally.

## Structure
- Package lsu_pkg: funct3 size localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum type lsu_state_t.
- Sub-module lsu_align: combinational be/wdata lane generation and load extraction/extension; FSM and registers in top.

## Test plan
- Store word 0xDEADBEEF to byte addr 0x010 -> ISSUE shows mem_addr=4, mem_be=1111, mem_we=1; resp_valid 2 cycles after accept.
- Load B from addr 0x013 with word 0x80FF0011 -> resp_rdata=0xFFFFFF80; LBU -> 0x00000080; resp_valid 3 cycles after accept.
- Store H 0x1234 to addr 0x006 -> mem_be=1100, mem_wdata=0x12341234; subsequent LHU at 0x006 -> 0x00001234.
- Load W at addr 0x005: with MISALIGN_TRAP_EN -> resp_err=1, mem_we/no ISSUE, resp 1 cycle after accept; without -> mem_addr=1, normal word load.
- resp_ready held 0 for 5 cycles in DONE -> resp_valid and resp_rdata stable, req_ready=0, new req_valid ignored.
- rst_n=0 during WAIT -> next cycle IDLE, resp_valid=0, req_ready=1, all mem outputs 0.
